// File: rtl/tpg_stream_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : tpg_stream_adapter_if
// Purpose  : Valid/ready pixel stream carrying frame and line sideband.
//            The master drives data, valid, sof and eol. The slave drives ready.
// Ports    : data  - pixel, 3*PW bits
//            valid - beat present
//            ready - beat accepted (a transfer happens when valid & ready)
//            sof   - first pixel of a frame
//            eol   - last pixel of a line
// Revision : 1.0 - initial release
// ============================================================================
interface tpg_stream_adapter_if #(
    parameter int PW = 8
);
    logic [3*PW-1:0] data;
    logic            valid;
    logic            ready;
    logic            sof;
    logic            eol;

    modport master (output data, output valid, output sof, output eol, input ready);
    modport slave  (input data, input valid, input sof, input eol, output ready);
endinterface
`default_nettype wire

// File: rtl/tpg_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tpg_stream_adapter
// Purpose  : Converts test-pattern raster output (vs/vld/rgb) into a
//            valid/ready pixel stream with sof/eol sideband. Pixels are
//            buffered in a show-ahead FIFO so that downstream backpressure is
//            absorbed. The raster side is never stalled. A pixel that arrives
//            while the FIFO is full is dropped and flagged as overflow.
//            The block also measures the active line length and the number
//            of active lines in each frame.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            hs           - raster hsync (not used for framing)
//            vs           - raster vsync, a rising edge starts a frame
//            vld, rgb     - raster pixel qualifier and pixel
//            m            - output stream (master modport)
//            overflow     - sticky flag set when a pixel is dropped
//            clr_ovf      - clears overflow (a drop in the same cycle wins)
//            line_len     - length of the last completed vld run
//            frame_lines  - number of runs in the last completed frame
// Revision : 1.0 - initial release
// ============================================================================
module tpg_stream_adapter #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int DEPTH  = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  hs,
    input  wire                  vs,
    input  wire                  vld,
    input  wire  [3*PW-1:0]      rgb,
    tpg_stream_adapter_if.master m,
    output logic                 overflow,
    input  wire                  clr_ovf,
    output logic [H_BITS-1:0]    line_len,
    output logic [V_BITS-1:0]    frame_lines
);
    localparam int                c_ADDR_W  = $clog2(DEPTH);
    localparam int                c_ENTRY_W = 3*PW + 2;
    localparam logic [c_ADDR_W:0] c_FULL    = (c_ADDR_W+1)'(DEPTH);

    // Raster state
    logic                  r_vsD;
    logic                  r_vldD;
    logic                  r_holdValid;
    logic                  r_holdSof;
    logic [3*PW-1:0]       r_holdPix;
    logic                  r_sofPending;
    logic [H_BITS-1:0]     r_hCount;
    logic [V_BITS-1:0]     r_vCount;

    // FIFO state; each entry is {sof, eol, pixel}
    logic [c_ENTRY_W-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wrPtr;
    logic [c_ADDR_W-1:0]   r_rdPtr;
    logic [c_ADDR_W:0]     r_count;

    logic                  w_vsRise;
    logic                  w_runEnd;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_write;
    logic                  w_drop;
    logic                  w_sofTaken;
    logic                  w_capSof;
    logic [c_ENTRY_W-1:0]  w_pushEntry;
    logic [c_ENTRY_W-1:0]  w_head;
    logic [V_BITS-1:0]     w_vNext;
    logic                  w_unusedHs;

    assign w_unusedHs  = hs;

    assign w_vsRise    = vs & ~r_vsD;
    assign w_runEnd    = r_vldD & ~vld;

    // The held pixel is the last one of its line exactly when vld has
    // dropped in the cycle in which it is pushed.
    assign w_push      = r_holdValid;
    assign w_pushEntry = {r_holdSof, ~vld, r_holdPix};

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_empty & m.ready;
    assign w_write     = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;

    // The pending flag stays set until its pixel is actually stored. A
    // pixel captured in the cycle that stores the sof pixel must not carry
    // sof again. If the sof pixel is dropped instead, the pending flag
    // stays set, so the pixel captured now carries sof.
    assign w_sofTaken  = w_write & r_holdSof;
    assign w_capSof    = r_sofPending & ~w_sofTaken;

    assign w_head      = r_mem[r_rdPtr];
    assign m.valid     = ~w_empty;
    assign m.data      = w_empty ? '0   : w_head[3*PW-1:0];
    assign m.eol       = w_empty ? 1'b0 : w_head[3*PW];
    assign m.sof       = w_empty ? 1'b0 : w_head[3*PW+1];

    // A run end in the vs_rise cycle is included in the latched line count.
    assign w_vNext     = (w_runEnd && !(&r_vCount)) ? r_vCount + 1'b1 : r_vCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsD        <= 1'b0;
            r_vldD       <= 1'b0;
            r_holdValid  <= 1'b0;
            r_holdSof    <= 1'b0;
            r_holdPix    <= '0;
            r_sofPending <= 1'b0;
        end else begin
            r_vsD        <= vs;
            r_vldD       <= vld;
            r_holdValid  <= vld;
            if (vld) begin
                r_holdPix <= rgb;
                r_holdSof <= w_capSof;
            end
            r_sofPending <= w_vsRise | (w_drop & r_holdSof) | (r_sofPending & ~w_sofTaken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // The storage array has no reset. The entries are only visible through
    // the occupancy count, and reset clears that count.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hCount    <= '0;
            r_vCount    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (vld) begin
                if (!(&r_hCount)) begin
                    r_hCount <= r_hCount + 1'b1;
                end
            end else if (w_runEnd) begin
                line_len <= r_hCount;
                r_hCount <= '0;
            end
            if (w_vsRise) begin
                frame_lines <= w_vNext;
                r_vCount    <= '0;
            end else begin
                r_vCount    <= w_vNext;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tpg_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpg_stream_adapter
// Purpose  : Directed self-checking bench for tpg_stream_adapter. A negedge
//            collector records every accepted beat and checks that a stalled
//            beat stays stable. The main sequence drives the raster and
//            compares the DUT against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpg_stream_adapter;
    logic        clk = 1'b0;
    logic        rst;
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
    logic        overflow;
    logic        clr_ovf;
    logic [11:0] line_len;
    logic [11:0] frame_lines;

    int          nCompared = 0;
    int          nMismatch = 0;
    int          stallErr  = 0;
    logic [25:0] beats[$];
    logic        prevStall = 1'b0;
    logic [25:0] prevBeat  = '0;
    logic        randReady;
    int          stallBudget;

    always #5 clk = ~clk;

    tpg_stream_adapter_if #(.PW(8)) m ();

    tpg_stream_adapter #(
        .PW(8), .H_BITS(12), .V_BITS(12), .DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .m(m), .overflow(overflow), .clr_ovf(clr_ovf),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    // Inputs change only at posedge+1, so valid & ready seen at the negedge
    // is the transfer that happens at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prevStall <= 1'b0;
        end else begin
            if (prevStall && !(m.valid && ({m.sof, m.eol, m.data} == prevBeat)))
                stallErr <= stallErr + 1;
            if (m.valid && m.ready)
                beats.push_back({m.sof, m.eol, m.data});
            prevStall <= m.valid && !m.ready;
            prevBeat  <= {m.sof, m.eol, m.data};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beatAt(input int idx);
        if (idx < beats.size()) return {6'b0, beats[idx]};
        return 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (randReady) begin
            if (stallBudget > 0 && $urandom_range(0, 1) == 0) begin
                m.ready = 1'b0;
                stallBudget--;
            end else begin
                m.ready = 1'b1;
            end
        end
    endtask

    task automatic pix(input logic [23:0] v);
        vld = 1'b1;
        rgb = v;
        tick();
    endtask

    task automatic vsPulse();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic runLine(input logic [23:0] first, input int len, input int gap);
        for (int i = 0; i < len; i++) pix(first + 24'(i));
        vld = 1'b0;
        rgb = '0;
        repeat (gap) tick();
    endtask

    // len = 0 means no beat in the sequence carries eol.
    task automatic checkBeats(input string tag, input int start, input int n,
                              input logic [23:0] first, input int len);
        logic [31:0] exp;
        check({tag, " count"}, 32'(beats.size() - start), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp = {6'b0, (i == 0), (len > 0 && (i % len) == len - 1), first + 24'(i)};
            check($sformatf("%s beat%0d", tag, i), beatAt(start + i), exp);
        end
    endtask

    initial begin
        int s;
        rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0; clr_ovf = 1'b0;
        m.ready = 1'b0; randReady = 1'b0; stallBudget = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Reset state
        check("rst valid", m.valid, 0);
        check("rst sof", m.sof, 0);
        check("rst eol", m.eol, 0);
        check("rst data", m.data, 0);
        check("rst overflow", overflow, 0);
        check("rst line_len", line_len, 0);
        check("rst frame_lines", frame_lines, 0);

        // 1) three lines of four pixels
        m.ready = 1'b1;
        vsPulse();
        check("t1 first frame_lines", frame_lines, 0);
        s = beats.size();
        runLine(24'd1, 4, 2);
        runLine(24'd5, 4, 2);
        runLine(24'd9, 4, 6);
        checkBeats("t1", s, 12, 24'd1, 4);
        check("t1 line_len", line_len, 4);
        vsPulse();
        check("t1 frame_lines", frame_lines, 3);

        // 2) two single-pixel runs
        s = beats.size();
        runLine(24'd100, 1, 3);
        runLine(24'd200, 1, 4);
        check("t2 count", 32'(beats.size() - s), 2);
        check("t2 beat0", beatAt(s), {6'b0, 1'b1, 1'b1, 24'd100});
        check("t2 beat1", beatAt(s + 1), {6'b0, 1'b0, 1'b1, 24'd200});
        check("t2 line_len", line_len, 1);

        // 3) overflow with the sink stalled
        m.ready = 1'b0;
        vsPulse();
        check("t3 frame_lines", frame_lines, 2);
        s = beats.size();
        runLine(24'd1001, 20, 2);
        check("t3 overflow", overflow, 1);
        check("t3 valid", m.valid, 1);
        check("t3 line_len", line_len, 20);
        m.ready = 1'b1;
        repeat (20) tick();
        checkBeats("t3", s, 16, 24'd1001, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3 clr_ovf", overflow, 0);

        // 4) full FIFO, push and pop in the same cycle
        m.ready = 1'b0;
        vsPulse();
        s = beats.size();
        for (int i = 0; i < 17; i++) pix(24'd2001 + 24'(i));
        m.ready = 1'b1;
        for (int i = 17; i < 30; i++) pix(24'd2001 + 24'(i));
        vld = 1'b0;
        repeat (40) tick();
        check("t4 overflow", overflow, 0);
        checkBeats("t4", s, 30, 24'd2001, 30);

        // 5) 64x8 frame, random stalls (50% per cycle, capped per line)
        randReady = 1'b1;
        vsPulse();
        check("t5 prev frame_lines", frame_lines, 1);
        s = beats.size();
        for (int l = 0; l < 8; l++) begin
            stallBudget = 12;
            runLine(24'd3000 + 24'(l * 64), 64, 40);
        end
        randReady = 1'b0;
        m.ready = 1'b1;
        repeat (10) tick();
        checkBeats("t5", s, 512, 24'd3000, 64);
        check("t5 stall stability", 32'(stallErr), 0);
        check("t5 overflow", overflow, 0);
        check("t5 line_len", line_len, 64);
        vsPulse();
        check("t5 frame_lines", frame_lines, 8);

        // 6) asynchronous reset mid-line with a partly full FIFO
        m.ready = 1'b0;
        vsPulse();
        for (int i = 0; i < 8; i++) pix(24'd4001 + 24'(i));
        check("t6 pre valid", m.valid, 1);
        rst = 1'b1;
        #2;
        check("t6 valid", m.valid, 0);
        check("t6 sof", m.sof, 0);
        check("t6 data", m.data, 0);
        check("t6 line_len", line_len, 0);
        check("t6 frame_lines", frame_lines, 0);
        vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m.ready = 1'b1;
        tick();
        check("t6 idle valid", m.valid, 0);
        s = beats.size();
        vsPulse();
        check("t6 first frame_lines", frame_lines, 0);
        runLine(24'd5001, 4, 6);
        checkBeats("t6", s, 4, 24'd5001, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
`default_nettype wire
